uart_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller serving the CPU data port for the 0x8000_00xx region. It is the peripheral that ROM-resident programs such as echo/loopback poll. It sequences UART traffic through an RX FIFO and a single-entry TX holding register, and it exposes a free-running cycle counter. It sits between the CPU memory stage and the UART rx/tx ready/valid interfaces.

---
 rtl/uart_mmio_pkg.sv | 24 ++
 rtl/io_sync_fifo.sv | 55 +++++
 rtl/uart_mmio_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_ctrl shared definitions.
// Register addresses and status bit positions.
package uart_mmio_pkg;

  localparam logic [31:0] TX_STAT_ADDR = 32'h8000_0000;
  localparam logic [31:0] RX_STAT_ADDR = 32'h8000_0004;
  localparam logic [31:0] TX_DATA_ADDR = 32'h8000_0008;
  localparam logic [31:0] RX_DATA_ADDR = 32'h8000_000C;
  localparam logic [31:0] CYCLE_ADDR   = 32'h8000_0010;

  localparam int TX_RDY_BIT = 0;
  localparam int TX_OVR_BIT = 1;
  localparam int RX_VLD_BIT = 0;
  localparam int RX_CNT_LSB = 8;

  // Word-aligned match; byte offset bits are ignored.
  function automatic logic addr_hit(
    input logic [31:0] a,
    input logic [31:0] base
  );
    return a[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO for received UART bytes.
// Occupancy counter is one bit wider than the pointers.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = r_count == (AW+1)'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO UART controller for the 0x8000_00xx region.
// RX FIFO, single TX holding register, cycle counter.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [31:0]    r_rdata;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic           r_tx_ovr;
  logic [CNT_W-1:0] r_cnt;

  logic           w_sel_txstat;
  logic           w_sel_rxstat;
  logic           w_sel_txdata;
  logic           w_sel_rxdata;
  logic           w_sel_cycle;
  logic           w_rx_push;
  logic           w_rx_pop;
  logic [7:0]     w_rx_head;
  logic           w_rx_full;
  logic           w_rx_empty;
  logic [AW:0]    w_rx_count;
  logic [31:0]    w_rd_val;
  logic           w_unused;

  assign w_sel_txstat = addr_hit(addr, TX_STAT_ADDR);
  assign w_sel_rxstat = addr_hit(addr, RX_STAT_ADDR);
  assign w_sel_txdata = addr_hit(addr, TX_DATA_ADDR);
  assign w_sel_rxdata = addr_hit(addr, RX_DATA_ADDR);
  assign w_sel_cycle  = addr_hit(addr, CYCLE_ADDR);

  assign w_rx_push = uart_rx_valid && !w_rx_full;
  assign w_rx_pop  = re && w_sel_rxdata && !w_rx_empty;
  assign w_unused  = ^{wdata[31:8], addr[1:0]};

  assign uart_rx_ready = !w_rx_full;
  assign uart_tx_data  = r_tx_data;
  assign uart_tx_valid = r_tx_valid;
  assign rdata         = r_rdata;

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (uart_rx_data),
    .dout  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

  // Load data mux from pre-edge state.
  always_comb begin
    w_rd_val = '0;
    unique case (1'b1)
      w_sel_txstat: begin
        w_rd_val[TX_RDY_BIT] = !r_tx_valid;
        w_rd_val[TX_OVR_BIT] = r_tx_ovr;
      end
      w_sel_rxstat: begin
        w_rd_val[RX_VLD_BIT]           = !w_rx_empty;
        w_rd_val[RX_CNT_LSB +: 8]      = 8'(w_rx_count);
      end
      w_sel_rxdata: begin
        if (!w_rx_empty) w_rd_val[7:0] = w_rx_head;
      end
      w_sel_cycle:  w_rd_val = 32'(r_cnt);
      default:      w_rd_val = '0;
    endcase
  end

  // Registered load data, held while no load is issued.
  always_ff @(posedge clk) begin
    if (rst)     r_rdata <= '0;
    else if (re) r_rdata <= w_rd_val;
  end

  // TX holding register; a completing handshake frees it for a same-cycle store.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_ovr   <= 1'b0;
    end else begin
      if (we && w_sel_txdata) begin
        if (!r_tx_valid || uart_tx_ready) begin
          r_tx_data  <= wdata[7:0];
          r_tx_valid <= 1'b1;
        end else begin
          r_tx_ovr   <= 1'b1;
        end
      end else if (r_tx_valid && uart_tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      if (we && w_sel_txstat) r_tx_ovr <= 1'b0;
    end
  end

  // Free-running cycle counter; a store clears it.
  always_ff @(posedge clk) begin
    if (rst || (we && w_sel_cycle)) r_cnt <= '0;
    else                            r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl.
// Queue-based reference model, directed plus random traffic.
module tb_uart_mmio_ctrl;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_TXS = 32'h8000_0000;
  localparam logic [31:0] A_RXS = 32'h8000_0004;
  localparam logic [31:0] A_TXD = 32'h8000_0008;
  localparam logic [31:0] A_RXD = 32'h8000_000C;
  localparam logic [31:0] A_CYC = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;

  uart_mmio_ctrl #(.RX_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .re            (re),
    .we            (we),
    .wdata         (wdata),
    .rdata         (rdata),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_rxq[$];
  logic        m_txv;
  logic [7:0]  m_txd;
  logic        m_ovr;
  logic [31:0] m_cnt;
  logic [31:0] rd_exp[$];
  logic [7:0]  tx_exp[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] wa);
    logic [31:0] v;
    int sz;
    sz = m_rxq.size();
    v  = '0;
    case (wa)
      A_TXS: v = {30'd0, m_ovr, ~m_txv};
      A_RXS: v = {16'd0, 8'(sz), 7'd0, sz != 0};
      A_RXD: v = (sz != 0) ? {24'd0, m_rxq[0]} : 32'd0;
      A_CYC: v = m_cnt;
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock: predict, advance the model, check the visible outputs.
  task automatic tick();
    logic [31:0] wa;
    logic do_push, do_pop, hs, wr_tx, wr_txs, wr_cyc;
    logic [7:0] rxb, txb;
    wa      = {addr[31:2], 2'b00};
    if (re && !rst) rd_exp.push_back(model_read(wa));
    do_push = uart_rx_valid && (m_rxq.size() < DEPTH);
    do_pop  = re && (wa == A_RXD) && (m_rxq.size() != 0);
    hs      = m_txv && uart_tx_ready;
    wr_tx   = we && (wa == A_TXD);
    wr_txs  = we && (wa == A_TXS);
    wr_cyc  = we && (wa == A_CYC);
    rxb     = uart_rx_data;
    txb     = wdata[7:0];
    @(posedge clk);
    #1;
    if (rst) begin
      m_rxq.delete();
      tx_exp.delete();
      m_txv = 1'b0;
      m_txd = '0;
      m_ovr = 1'b0;
      m_cnt = '0;
      chk("rst_rdata", rdata, 32'd0);
    end else begin
      if (do_pop) void'(m_rxq.pop_front());
      if (do_push) m_rxq.push_back(rxb);
      if (wr_tx) begin
        if (!m_txv || hs) begin
          m_txd = txb;
          m_txv = 1'b1;
          tx_exp.push_back(txb);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_txv = 1'b0;
      end
      if (wr_txs) m_ovr = 1'b0;
      m_cnt = wr_cyc ? 32'd0 : m_cnt + 32'd1;
    end
    chk("rx_ready", {31'd0, uart_rx_ready}, {31'd0, m_rxq.size() < DEPTH});
    chk("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_txv});
    chk("tx_data", {24'd0, uart_tx_data}, {24'd0, m_txd});
  endtask

  task automatic op(input logic r, input logic w,
                    input logic [31:0] a, input logic [31:0] d);
    re = r; we = w; addr = a; wdata = d;
    tick();
    re = 1'b0; we = 1'b0;
  endtask

  // Monitor: compares load data and transmitted bytes against the queues.
  initial begin
    logic s_re, s_rst, s_hs;
    logic [7:0] s_txd;
    logic [31:0] last_rd;
    last_rd = '0;
    forever begin
      @(negedge clk);
      s_re  = re;
      s_rst = rst;
      s_hs  = uart_tx_valid && uart_tx_ready;
      s_txd = uart_tx_data;
      @(posedge clk);
      #2;
      if (s_rst) begin
        last_rd = '0;
      end else begin
        if (s_re) begin
          if (rd_exp.size() == 0) begin
            chk("rd_queue_empty", 32'd1, 32'd0);
          end else begin
            last_rd = rd_exp.pop_front();
            chk("rdata", rdata, last_rd);
          end
        end else begin
          chk("rdata_hold", rdata, last_rd);
        end
        if (s_hs) begin
          if (tx_exp.size() == 0) chk("tx_unexpected", {24'd0, s_txd}, 32'hFFFF_FFFF);
          else chk("tx_byte", {24'd0, s_txd}, {24'd0, tx_exp.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [31:0] addrs [7];
    addrs = '{A_TXS, A_RXS, A_TXD, A_RXD, A_CYC, 32'h8000_0014, 32'h0000_000C};

    // 1: reset and idle status
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    op(1, 0, A_TXS, 0);
    op(1, 0, A_RXS, 0);
    op(1, 0, A_CYC, 0);

    // 2: two received bytes
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h41; tick();
    uart_rx_data  = 8'h42; tick();
    uart_rx_valid = 1'b0;
    op(1, 0, A_RXS, 0);
    op(1, 0, A_RXD, 0);
    op(1, 0, A_RXD, 0);
    op(1, 0, A_RXS, 0);
    op(1, 0, A_RXD, 0);

    // 3: fill, backpressure, pop with pending push, wrap order
    uart_rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      uart_rx_data = 8'(i);
      tick();
    end
    uart_rx_data = 8'h08;
    tick();
    tick();
    op(1, 0, A_RXD, 0);
    tick();
    uart_rx_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) op(1, 0, A_RXD, 0);

    // empty FIFO: push and read together returns 0, byte stays
    uart_rx_valid = 1'b1; uart_rx_data = 8'hA5;
    op(1, 0, A_RXD, 0);
    uart_rx_valid = 1'b0;
    op(1, 0, A_RXD, 0);

    // 4: overrun
    uart_tx_ready = 1'b0;
    op(0, 1, A_TXD, 32'h55);
    op(0, 1, A_TXD, 32'h66);
    op(1, 0, A_TXS, 0);
    uart_tx_ready = 1'b1; tick();
    uart_tx_ready = 1'b0;
    op(1, 0, A_TXS, 0);
    op(0, 1, A_TXS, 0);
    op(1, 0, A_TXS, 0);

    // 5: back-to-back stores with the UART always ready
    uart_tx_ready = 1'b1;
    op(0, 1, A_TXD, 32'h10);
    op(0, 1, A_TXD, 32'h11);
    tick();
    op(1, 0, A_TXS, 0);
    uart_tx_ready = 1'b0;

    // 6: counter clear, simultaneous read/write, then reset mid-traffic
    op(0, 1, A_CYC, 0);
    op(1, 0, A_CYC, 0);
    op(1, 1, A_CYC, 0);
    op(1, 0, A_CYC, 0);
    op(0, 1, A_TXD, 32'h77);
    uart_rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      uart_rx_data = 8'(8'hC0 + i);
      tick();
    end
    uart_rx_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    op(1, 0, A_TXS, 0);
    op(1, 0, A_RXS, 0);
    op(1, 0, A_CYC, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      uart_rx_valid = ($urandom_range(0, 1) == 1);
      uart_rx_data  = 8'($urandom);
      uart_tx_ready = ($urandom_range(0, 9) < 3);
      rst   = ($urandom_range(0, 499) == 0);
      re    = !rst && ($urandom_range(0, 1) == 1);
      we    = ($urandom_range(0, 3) == 0);
      addr  = addrs[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      wdata = $urandom;
      tick();
    end
    rst = 1'b0; re = 1'b0; we = 1'b0;
    tick();
    tick();
    #5;
    chk("rd_queue_drained", rd_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
